instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 149 ++++++++++++++
 tb/tb_instr_fetch.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC sequencer feeding a 2-entry (instruction, PC) queue.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN. When defined, a redirect
// to a non-word-aligned target halts fetch and raises fetch_misaligned until
// an aligned redirect arrives. When undefined, redirect targets are
// word-aligned by clearing bits [1:0], and there is no HALT state.
`timescale 1ns/1ps
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction_code,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;
`else
  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic [31:0] q_instr_q [2];
  logic [31:0] q_pc_q    [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        push, pop;
  logic [1:0]  occ_after_pop;
  logic [31:0] redirect_tgt;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misalign_q;
  logic        redirect_misaligned;
  assign redirect_misaligned = |redirect_pc[1:0];
  assign redirect_tgt        = redirect_pc;
  assign fetch_misaligned    = misalign_q;
`else
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign instr_valid = (count_q != 2'd0);
  assign pop         = instr_valid & instr_ready;
  // A redirect discards whatever response lands in the same cycle.
  assign push        = inflight_q & ~redirect_valid;
  // Counting the same-cycle pop lets a steady stream sustain one fetch per cycle
  // while still guaranteeing the queue can absorb every outstanding response.
  assign occ_after_pop = count_q - {1'b0, pop} + {1'b0, inflight_q};
  assign imem_req    = (state_q == RUN) && !redirect_valid && (occ_after_pop < 2'd2);
  assign imem_addr   = pc_q;

  // Empty queue presents zeros so nothing stale leaks to decode.
  assign instruction_code = instr_valid ? q_instr_q[rd_ptr_q] : 32'h0;
  assign instr_pc         = instr_valid ? q_pc_q[rd_ptr_q]    : 32'h0;

  // Next fetch PC: redirect wins, otherwise advance (wrapping) on each request.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = redirect_tgt;
    else if (imem_req)
      pc_d = pc_q + 32'd4;
  end

  // Next queue occupancy: flushed on redirect, else push/pop bookkeeping.
  always_comb begin
    count_d = count_q;
    if (redirect_valid)
      count_d = 2'd0;
    else
      count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Fetch sequencer: state, PC and the single outstanding request tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_req;
      if (imem_req)
        inflight_pc_q <= pc_q;
      case (state_q)
        BOOT:    state_q <= RUN;
        default: ;
      endcase
      if (redirect_valid) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (redirect_misaligned) begin
          state_q    <= HALT;
          misalign_q <= 1'b1;
        end else begin
          state_q    <= RUN;
          misalign_q <= 1'b0;
        end
`else
        state_q <= RUN;
`endif
      end
    end
  end

  // Two-entry response queue in program order; pointers wrap modulo 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_instr_q[i] <= 32'h0;
        q_pc_q[i]    <= 32'h0;
      end
    end else begin
      count_q <= count_d;
      if (redirect_valid) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          q_instr_q[wr_ptr_q] <= imem_rdata;
          q_pc_q[wr_ptr_q]    <= inflight_pc_q;
          wr_ptr_q            <= ~wr_ptr_q;
        end
        if (pop)
          rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: transaction-level queue model checked every
// cycle, plus directed literal expectations for latency, stall, redirect,
// wrap-around and mid-stream reset. A second instance covers RESET_PC near
// the top of the address space.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction_code;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
  logic        w_mis;
`endif

  logic        rst_w;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata = 32'hDEAD_BEEF;
  logic [31:0] w_code;
  logic [31:0] w_pc;
  logic        w_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instruction_code (instruction_code),
    .instr_pc         (instr_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk              (clk),
    .reset            (rst_w),
    .imem_req         (w_req),
    .imem_addr        (w_addr),
    .imem_rdata       (w_rdata),
    .redirect_valid   (1'b0),
    .redirect_pc      (32'h0),
    .instruction_code (w_code),
    .instr_pc         (w_pc),
    .instr_valid      (w_valid),
    .instr_ready      (1'b1)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (w_mis)
`endif
  );

  // Memories: one-cycle read latency, data = address + 0x100.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? imem_addr + 32'h100 : 32'hDEAD_BEEF;
    w_rdata    <= w_req ? w_addr + 32'h100 : 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // mq holds the PCs of responses already queued, in program order.
  // A single outstanding request (infl/infl_pc) turns into a queue entry at
  // the next edge unless a redirect or reset intervenes.
  logic [31:0] mq[$];
  bit          infl;
  logic [31:0] infl_pc;
  logic [31:0] exp_fetch;
  bit          boot;
  bit          halted;
  bit          m_hs;
  bit          m_req;
  int          m_occ;

  always @(negedge clk) begin
    if (reset) begin
      chk1("rst_valid", instr_valid, 1'b0);
      chk1("rst_req", imem_req, 1'b0);
      chk("rst_code", instruction_code, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
      chk1("rst_mis", fetch_misaligned, 1'b0);
`endif
      mq.delete();
      infl      = 1'b0;
      exp_fetch = 32'h0;
      boot      = 1'b1;
      halted    = 1'b0;
    end else begin
      m_hs  = (mq.size() != 0) && instr_ready;
      m_occ = mq.size() - (m_hs ? 1 : 0) + (infl ? 1 : 0);
      m_req = !boot && !halted && !redirect_valid && (m_occ < 2);
      chk1("m_valid", instr_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("m_pc", instr_pc, mq[0]);
        chk("m_code", instruction_code, mq[0] + 32'h100);
      end else begin
        chk("m_pc_idle", instr_pc, 32'h0);
        chk("m_code_idle", instruction_code, 32'h0);
      end
      chk1("m_req", imem_req, m_req);
      if (m_req)
        chk("m_addr", imem_addr, exp_fetch);
`ifdef IFETCH_MISALIGN_TRAP_EN
      chk1("m_mis", fetch_misaligned, halted);
`endif
      boot = 1'b0;
      if (redirect_valid) begin
        mq.delete();
        infl = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        halted    = (redirect_pc[1:0] != 2'b00);
        exp_fetch = redirect_pc;
`else
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
`endif
      end else begin
        if (m_hs) void'(mq.pop_front());
        if (infl) mq.push_back(infl_pc);
        infl = m_req;
        if (m_req) begin
          infl_pc   = exp_fetch;
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
  end

  // Capture the first three deliveries of the high-RESET_PC instance.
  logic [31:0] w_pcs[3];
  logic [31:0] w_codes[3];
  int          w_n = 0;
  always @(negedge clk) begin
    if (!rst_w && w_valid && w_n < 3) begin
      w_pcs[w_n]   = w_pc;
      w_codes[w_n] = w_code;
      w_n++;
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic        lat_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] lat_pc[6] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] wexp  [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

  initial begin
    reset          = 1'b1;
    rst_w          = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) cyc();
    #2;
    chk1("inrst_req", imem_req, 1'b0);
    chk1("inrst_valid", instr_valid, 1'b0);
    chk("inrst_code", instruction_code, 32'h0);
    chk("inrst_pc", instr_pc, 32'h0);

    // First fetch after reset and full-rate streaming.
    cyc();
    reset = 1'b0;
    rst_w = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      #2;
      chk1("lat_valid", instr_valid, lat_v[k]);
      if (lat_v[k]) chk("lat_pc", instr_pc, lat_pc[k]);
      if (k == 0) begin
        chk1("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);
      end
    end

    // Decode stalled: queue fills to two, fetch stops, then resumes at 8.
    cyc();
    reset = 1'b1;
    instr_ready = 1'b0;
    cyc();
    reset = 1'b0;
    repeat (5) cyc();
    #2;
    chk1("stall_req", imem_req, 1'b0);
    chk1("stall_valid", instr_valid, 1'b1);
    chk("stall_head", instr_pc, 32'h0);
    cyc();
    instr_ready = 1'b1;
    #2;
    chk("rel_pc0", instr_pc, 32'h0);
    chk1("rel_req", imem_req, 1'b1);
    chk("rel_addr", imem_addr, 32'h8);
    cyc();
    #2;
    chk("rel_pc4", instr_pc, 32'h4);
    cyc();
    #2;
    chk("rel_pc8", instr_pc, 32'h8);

    // Redirect with a full queue and a same-cycle handshake.
    instr_ready = 1'b0;
    repeat (4) cyc();
    #2;
    chk1("full_valid", instr_valid, 1'b1);
    chk1("full_req", imem_req, 1'b0);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    instr_ready    = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    #2;
    chk1("rd_flush", instr_valid, 1'b0);
    chk1("rd_req", imem_req, 1'b1);
    chk("rd_addr", imem_addr, 32'h40);
    cyc();
    #2;
    chk1("rd_gap", instr_valid, 1'b0);
    cyc();
    #2;
    chk1("rd_valid", instr_valid, 1'b1);
    chk("rd_pc", instr_pc, 32'h40);

    // Redirect mid-stream with a response arriving in the same cycle.
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    #2;
    chk1("rd2_flush", instr_valid, 1'b0);
    cyc();
    cyc();
    #2;
    chk("rd2_pc", instr_pc, 32'h200);

    // Misaligned redirect target.
    repeat (2) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    cyc();
    redirect_valid = 1'b0;
    #2;
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk1("mis_flag", fetch_misaligned, 1'b1);
    chk1("mis_req", imem_req, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      #2;
      chk1("halt_req", imem_req, 1'b0);
      chk1("halt_flag", fetch_misaligned, 1'b1);
    end
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    cyc();
    redirect_valid = 1'b0;
    #2;
    chk1("unhalt_flag", fetch_misaligned, 1'b0);
    chk1("unhalt_req", imem_req, 1'b1);
    chk("unhalt_addr", imem_addr, 32'h80);
`else
    chk1("align_req", imem_req, 1'b1);
    chk("align_addr", imem_addr, 32'h40);
`endif

    // Fetch PC wrap-around through a redirect near the top of memory.
    repeat (2) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    #2;
    chk("wrap_a0", imem_addr, 32'hFFFF_FFF8);
    cyc();
    #2;
    chk("wrap_a1", imem_addr, 32'hFFFF_FFFC);
    cyc();
    #2;
    chk("wrap_a2", imem_addr, 32'h0000_0000);
    chk1("wrap_req", imem_req, 1'b1);

    // Reset pulse mid-stream with two entries queued.
    instr_ready = 1'b0;
    repeat (5) cyc();
    #2;
    chk1("prerst_valid", instr_valid, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk1("arst_valid", instr_valid, 1'b0);
    chk("arst_pc", instr_pc, 32'h0);
    chk("arst_code", instruction_code, 32'h0);
    chk1("arst_req", imem_req, 1'b0);
    cyc();
    reset = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #2;
      chk1("rerun_valid", instr_valid, lat_v[k]);
      if (lat_v[k]) chk("rerun_pc", instr_pc, lat_pc[k]);
    end

    // High RESET_PC instance delivered its first three PCs across the wrap.
    repeat (2) cyc();
    chk("wrap_count", w_n, 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < w_n) begin
        chk("wrap_pc", w_pcs[k], wexp[k]);
        chk("wrap_code", w_codes[k], wexp[k] + 32'h100);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
